uart_rx_ctrl: RTL and testbench



---
 rtl/uart_rx_ctrl_if.sv | 27 ++
 rtl/uart_rx_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Control-to-datapath bundle for the UART receiver: raw rx pin in, strobes and status out.
// master = uart_rx_ctrl, slave = the pin/datapath side.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                          rx;
    logic                          clear_data;
    logic                          shift_en;
    logic                          data_bit;
    logic [$clog2(DATA_WIDTH)-1:0] bit_count;
    logic                          rx_valid;
    logic                          frame_err;
    logic                          parity_err;
    logic                          busy;

    modport master (
        input  rx,
        output clear_data, shift_en, data_bit, bit_count,
        output rx_valid, frame_err, parity_err, busy
    );

    modport slave (
        output rx,
        input  clear_data, shift_en, data_bit, bit_count,
        input  rx_valid, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive control FSM: synchronizes rx, times mid-bit samples and strobes the datapath.
// Define UART_RX_PARITY_EN to add a parity bit between the data bits and the stop bit.
module uart_rx_ctrl #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input logic           clock,
    input logic           reset,
    uart_rx_ctrl_if.master ifc
);
    localparam int CPS_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CPS     = (CPS_RAW < 1) ? 1 : CPS_RAW;
    localparam int CW      = (CPS > 1) ? $clog2(CPS) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] CLK_LAST  = CW'(CPS - 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic          PAR_SEED  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t         r_state;
    logic           r_sync1, r_sync2, r_rxPrev;
    logic [CW-1:0]  r_clkCount;
    logic [SW-1:0]  r_sampleCount;
    logic [BW-1:0]  r_bitCount;
    logic           r_clearData, r_shiftEn, r_dataBit, r_rxValid, r_frameErr;
    logic           w_rxS, w_tick;

    assign w_rxS  = r_sync2;
    assign w_tick = (r_clkCount == CLK_LAST);

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle line is high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_sync1  <= ifc.rx;
            r_sync2  <= r_sync1;
            r_rxPrev <= r_sync2;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity, r_parityBad, r_parityErr;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_clkCount    <= '0;
            r_sampleCount <= '0;
            r_bitCount    <= '0;
            r_clearData   <= 1'b0;
            r_shiftEn     <= 1'b0;
            r_dataBit     <= 1'b0;
            r_rxValid     <= 1'b0;
            r_frameErr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity      <= 1'b0;
            r_parityBad   <= 1'b0;
            r_parityErr   <= 1'b0;
`endif
        end else begin
            r_clearData <= 1'b0;
            r_shiftEn   <= 1'b0;
            r_rxValid   <= 1'b0;
            r_frameErr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parityErr <= 1'b0;
`endif
            r_clkCount  <= w_tick ? '0 : r_clkCount + 1'b1;

            case (r_state)
                IDLE: begin
                    if (!w_rxS && r_rxPrev) begin
                        r_state       <= START;
                        r_clkCount    <= '0;
                        r_sampleCount <= '0;
                    end
                end

                // Re-check the line half a bit in so short glitches are rejected.
                START: begin
                    if (w_tick) begin
                        if (r_sampleCount == HALF_LAST) begin
                            r_sampleCount <= '0;
                            if (w_rxS) begin
                                r_state <= IDLE;
                            end else begin
                                r_clearData <= 1'b1;
                                r_bitCount  <= '0;
                                r_state     <= DATA;
`ifdef UART_RX_PARITY_EN
                                r_parity    <= PAR_SEED;
`endif
                            end
                        end else begin
                            r_sampleCount <= r_sampleCount + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (w_tick) begin
                        if (r_sampleCount == FULL_LAST) begin
                            r_sampleCount <= '0;
                            r_shiftEn     <= 1'b1;
                            r_dataBit     <= w_rxS;
`ifdef UART_RX_PARITY_EN
                            r_parity      <= r_parity ^ w_rxS;
`endif
                            if (r_bitCount == BIT_LAST) begin
                                r_bitCount <= '0;
`ifdef UART_RX_PARITY_EN
                                r_state    <= PARITY;
`else
                                r_state    <= STOP;
`endif
                            end else begin
                                r_bitCount <= r_bitCount + 1'b1;
                            end
                        end else begin
                            r_sampleCount <= r_sampleCount + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                // r_parity was seeded with the odd/even choice, so it equals the expected parity bit.
                PARITY: begin
                    if (w_tick) begin
                        if (r_sampleCount == FULL_LAST) begin
                            r_sampleCount <= '0;
                            r_parityBad   <= (w_rxS != r_parity);
                            r_state       <= STOP;
                        end else begin
                            r_sampleCount <= r_sampleCount + 1'b1;
                        end
                    end
                end
`endif

                STOP: begin
                    if (w_tick) begin
                        if (r_sampleCount == FULL_LAST) begin
                            r_sampleCount <= '0;
                            r_rxValid     <= w_rxS;
                            r_frameErr    <= !w_rxS;
`ifdef UART_RX_PARITY_EN
                            r_parityErr   <= r_parityBad;
`endif
                            r_state       <= IDLE;
                        end else begin
                            r_sampleCount <= r_sampleCount + 1'b1;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign ifc.clear_data = r_clearData;
    assign ifc.shift_en   = r_shiftEn;
    assign ifc.data_bit   = r_dataBit;
    assign ifc.bit_count  = r_bitCount;
    assign ifc.rx_valid   = r_rxValid;
    assign ifc.frame_err  = r_frameErr;
    assign ifc.busy       = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign ifc.parity_err = r_parityErr;
`else
    assign ifc.parity_err = PAR_SEED & 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frames, glitch, reset abort, back-to-back
// and random frames, checked against a bit-period timing model of the serial line.
module tb_uart_rx_ctrl;
    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD_RATE  = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_WIDTH = 8;
    localparam int PARITY_ODD = 0;
    localparam int BIT_CYC    = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_rx_ctrl_if #(.DATA_WIDTH(DATA_WIDTH)) ifc ();

    uart_rx_ctrl #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_WIDTH(DATA_WIDTH),
        .OVERSAMPLE(OVERSAMPLE), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ifc(ifc)
    );

    // Strobe log, sampled on the falling edge with the cycle number of each event.
    int   clrCyc[$], shCyc[$], shBit[$], shCnt[$], vCyc[$], vBusy[$], fCyc[$], pCyc[$];
    int   multiCount = 0;
    logic prevBusy = 1'b0;

    always @(negedge clock) begin
        if (ifc.clear_data) clrCyc.push_back(cyc);
        if (ifc.shift_en) begin
            shCyc.push_back(cyc);
            shBit.push_back(int'(ifc.data_bit));
            shCnt.push_back(int'(ifc.bit_count));
        end
        if (ifc.rx_valid) begin
            vCyc.push_back(cyc);
            vBusy.push_back(int'({prevBusy, ifc.busy}));
        end
        if (ifc.frame_err) fCyc.push_back(cyc);
        if (ifc.parity_err) pCyc.push_back(cyc);
        if (int'(ifc.clear_data) + int'(ifc.shift_en) + int'(ifc.rx_valid) + int'(ifc.frame_err) > 1)
            multiCount++;
        prevBusy = ifc.busy;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int outVec();
        return int'({ifc.clear_data, ifc.shift_en, ifc.data_bit, ifc.bit_count,
                     ifc.rx_valid, ifc.frame_err, ifc.parity_err, ifc.busy});
    endfunction

    function automatic logic expParity(input logic [7:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    task automatic clearLog();
        clrCyc.delete(); shCyc.delete(); shBit.delete(); shCnt.delete();
        vCyc.delete(); vBusy.delete(); fCyc.delete(); pCyc.delete();
    endtask

    task automatic driveBit(input logic v);
        ifc.rx = v;
        repeat (BIT_CYC) @(negedge clock);
    endtask

    // Drives one complete frame starting on a falling clock edge; line is left at the stop value.
    task automatic applyStimulus(input logic [7:0] data, input logic parBit, input logic stopBit,
                                 output int t0);
        t0 = cyc;
        driveBit(1'b0);
        for (int i = 0; i < DATA_WIDTH; i++) driveBit(data[i]);
        if (PAR == 1) driveBit(parBit);
        driveBit(stopBit);
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] data, input logic parBit,
                              input logic stopBit, input int t0);
        int         oc, lat, nBadGap, nBadCnt;
        logic [7:0] got;
        bit         parBad;
        parBad = (PAR == 1) && (parBit != expParity(data));
        oc = -1;
        checkOutput({tag, ".nClear"}, clrCyc.size(), 1);
        checkOutput({tag, ".nShift"}, shCyc.size(), DATA_WIDTH);
        if (clrCyc.size() == 1 && shCyc.size() == DATA_WIDTH) begin
            lat = clrCyc[0] - t0;
            checkOutput({tag, ".clearLatOk"}, int'(lat >= 80 && lat <= 86), 1);
            got = '0;
            nBadGap = 0;
            nBadCnt = 0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                got[i] = shBit[i][0];
                if (shCyc[i] - ((i == 0) ? clrCyc[0] : shCyc[i-1]) != BIT_CYC) nBadGap++;
                if (shCnt[i] != (i + 1) % DATA_WIDTH) nBadCnt++;
            end
            checkOutput({tag, ".data"}, int'(got), int'(data));
            checkOutput({tag, ".badGaps"}, nBadGap, 0);
            checkOutput({tag, ".badBitCount"}, nBadCnt, 0);
        end
        checkOutput({tag, ".nValid"}, vCyc.size(), stopBit ? 1 : 0);
        checkOutput({tag, ".nFrameErr"}, fCyc.size(), stopBit ? 0 : 1);
        if (stopBit && vCyc.size() == 1) oc = vCyc[0];
        if (!stopBit && fCyc.size() == 1) oc = fCyc[0];
        if (oc >= 0 && shCyc.size() == DATA_WIDTH)
            checkOutput({tag, ".outcomeGap"}, oc - shCyc[DATA_WIDTH-1], BIT_CYC * (1 + PAR));
        if (stopBit && vBusy.size() == 1)
            checkOutput({tag, ".busyFall"}, vBusy[0], 2);
        checkOutput({tag, ".nParityErr"}, pCyc.size(), int'(parBad));
        if (parBad && pCyc.size() == 1 && oc >= 0)
            checkOutput({tag, ".parityErrCycle"}, pCyc[0], oc);
    endtask

    initial begin
        int         t0, t1, gap;
        logic [7:0] d;
        logic       s, p;
        logic [15:0] bits16;

        ifc.rx = 1'b1;
        reset  = 1'b1;
        #2 reset = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("reset.outputs", outVec(), 0);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        clearLog();

        // Plain frame with good stop bit.
        applyStimulus(8'hA5, expParity(8'hA5), 1'b1, t0);
        repeat (50) @(negedge clock);
        checkFrame("A5", 8'hA5, expParity(8'hA5), 1'b1, t0);
        checkOutput("A5.busyIdle", int'(ifc.busy), 0);
        clearLog();

        // Short low glitch must be rejected at the half-bit check.
        ifc.rx = 1'b0;
        repeat (20) @(negedge clock);
        checkOutput("glitch.busyHigh", int'(ifc.busy), 1);
        repeat (20) @(negedge clock);
        ifc.rx = 1'b1;
        repeat (200) @(negedge clock);
        checkOutput("glitch.nClear", clrCyc.size(), 0);
        checkOutput("glitch.nShift", shCyc.size(), 0);
        checkOutput("glitch.busyIdle", int'(ifc.busy), 0);
        clearLog();

        // Bad stop bit with the line then held low: single frame error, no retrigger.
        applyStimulus(8'h3C, expParity(8'h3C), 1'b0, t0);
        repeat (2000) @(negedge clock);
        checkFrame("3C.ferr", 8'h3C, expParity(8'h3C), 1'b0, t0);
        checkOutput("3C.busyIdle", int'(ifc.busy), 0);
        ifc.rx = 1'b1;
        repeat (20) @(negedge clock);
        clearLog();

        // Reset in the middle of a frame after three shifts.
        d = 8'h5A;
        driveBit(1'b0);
        for (int i = 0; i < 3; i++) driveBit(d[i]);
        ifc.rx = d[3];
        repeat (40) @(negedge clock);
        checkOutput("rst.shiftsBefore", shCyc.size(), 3);
        reset = 1'b0;
        #1;
        checkOutput("rst.asyncOutputs", outVec(), 0);
        ifc.rx = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        clearLog();
        repeat (300) @(negedge clock);
        checkOutput("rst.quiet", clrCyc.size() + shCyc.size() + vCyc.size() + fCyc.size(), 0);
        applyStimulus(8'h3C, expParity(8'h3C), 1'b1, t0);
        repeat (50) @(negedge clock);
        checkFrame("rst.3C", 8'h3C, expParity(8'h3C), 1'b1, t0);
        clearLog();

        // Back-to-back frames with no idle gap.
        applyStimulus(8'h00, expParity(8'h00), 1'b1, t0);
        applyStimulus(8'hFF, expParity(8'hFF), 1'b1, t1);
        repeat (50) @(negedge clock);
        checkOutput("b2b.nValid", vCyc.size(), 2);
        if (vCyc.size() == 2)
            checkOutput("b2b.validSpacing", vCyc[1] - vCyc[0], BIT_CYC * (10 + PAR));
        checkOutput("b2b.nShift", shCyc.size(), 16);
        if (shBit.size() == 16) begin
            bits16 = '0;
            for (int i = 0; i < 16; i++) bits16[i] = shBit[i][0];
            checkOutput("b2b.bits", int'(bits16), 16'hFF00);
        end
        checkOutput("b2b.nFrameErr", fCyc.size(), 0);
        clearLog();

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1, so 0 is a mismatch.
        applyStimulus(8'h07, 1'b0, 1'b1, t0);
        repeat (50) @(negedge clock);
        checkFrame("par07.bad", 8'h07, 1'b0, 1'b1, t0);
        clearLog();
        applyStimulus(8'h07, 1'b1, 1'b1, t0);
        repeat (50) @(negedge clock);
        checkFrame("par07.good", 8'h07, 1'b1, 1'b1, t0);
        clearLog();
`endif

        // Random frames, random stop/parity faults and idle gaps.
        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            p = expParity(d) ^ ($urandom_range(0, 3) == 0);
            applyStimulus(d, p, s, t0);
            checkFrame("rand", d, p, s, t0);
            clearLog();
            ifc.rx = 1'b1;
            gap = s ? $urandom_range(0, 100) : $urandom_range(2, 100);
            repeat (gap) @(negedge clock);
        end
        repeat (200) @(negedge clock);
        checkOutput("end.busyIdle", int'(ifc.busy), 0);
        checkOutput("oneStrobePerCycle", multiCount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
